// File: rtl/zero_pad_pkg.sv
// -----------------------------------------------------------------------------
// zero_pad_pkg
// Shared types and elaboration-time helpers for the streaming zero-padder.
//   pad_state_e : padder control state (idle / walking a frame)
//   out_dim     : padded dimension, img + 2*pad
//   cnt_w       : counter width for n positions, never below 1 bit
// -----------------------------------------------------------------------------
package zero_pad_pkg;

  typedef enum logic {
    PAD_IDLE = 1'b0,
    PAD_RUN  = 1'b1
  } pad_state_e;

  function automatic int out_dim(input int img, input int pad);
    return img + 2 * pad;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/zero_pad_pos_cnt.sv
// -----------------------------------------------------------------------------
// zero_pad_pos_cnt
// Raster-order position counter over a W x H grid, column fastest.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   inc          : advance one position (wraps (H-1,W-1) -> (0,0))
//   clr          : force position back to (0,0); wins over inc
//   row, col     : current position
//   last_col     : col == W-1
//   last_pos     : row == H-1 && col == W-1
// -----------------------------------------------------------------------------
module zero_pad_pos_cnt
  import zero_pad_pkg::*;
#(
  parameter int W = 5,
  parameter int H = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  clr,
  output logic [cnt_w(H)-1:0]   row,
  output logic [cnt_w(W)-1:0]   col,
  output logic                  last_col,
  output logic                  last_pos
);

  localparam int RW = cnt_w(H);
  localparam int CW = cnt_w(W);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_last_col;
  logic          w_last_row;

  assign w_last_col = (r_col == COL_MAX);
  assign w_last_row = (r_row == ROW_MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (inc) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign row      = r_row;
  assign col      = r_col;
  assign last_col = w_last_col;
  assign last_pos = w_last_col && w_last_row;

endmodule

// File: rtl/zero_pad_stream.sv
// -----------------------------------------------------------------------------
// zero_pad_stream
// Streaming zero-padder: takes an IMG_H x IMG_W map in raster order (CH lanes
// per beat) and emits the (IMG_H+2*PAD) x (IMG_W+2*PAD) map with PAD rings of
// zeros, plus sof/eol/eof markers. Border beats are generated locally and never
// wait on the input; interior beats pass input data through bit-exact.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   en                 : start a frame from idle / continue into the next frame
//   in_valid/in_ready  : input handshake, in_data lane k at [k*DATA_W +: DATA_W]
//   out_valid/out_ready: output handshake (out_valid registered)
//   out_data           : padded beat
//   out_sof/eol/eof    : first beat of frame / last beat of row / last of frame
//   busy               : a frame is in progress
//   frame_cnt          : completed-frame count, only with ZERO_PAD_FRAME_CNT_EN
// Build option: define ZERO_PAD_FRAME_CNT_EN to add the frame_cnt port.
// -----------------------------------------------------------------------------
module zero_pad_stream
  import zero_pad_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CH     = 1,
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int PAD    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic                 out_eof,
  output logic                 busy
`ifdef ZERO_PAD_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int OW = out_dim(IMG_W, PAD);
  localparam int OH = out_dim(IMG_H, PAD);
  localparam int RW = cnt_w(OH);
  localparam int CW = cnt_w(OW);

  pad_state_e          r_state;
  logic                r_out_valid;
  logic [CH*DATA_W-1:0] r_out_data;
  logic                r_out_sof;
  logic                r_out_eol;
  logic                r_out_eof;

  logic [RW-1:0]       w_row;
  logic [CW-1:0]       w_col;
  logic                w_last_col;
  logic                w_last_pos;
  logic                w_interior;
  logic                w_slot;
  logic                w_run;
  logic                w_load;

  zero_pad_pos_cnt #(
    .W (OW),
    .H (OH)
  ) u_pos (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_load),
    .clr      (r_state == PAD_IDLE),
    .row      (w_row),
    .col      (w_col),
    .last_col (w_last_col),
    .last_pos (w_last_pos)
  );

  // With no padding every position is interior; this also avoids a
  // comparison against zero that is always true.
  generate
    if (PAD == 0) begin : g_nopad
      assign w_interior = 1'b1;
    end else begin : g_pad
      localparam logic [RW-1:0] ROW_LO = RW'(PAD);
      localparam logic [RW-1:0] ROW_HI = RW'(PAD + IMG_H - 1);
      localparam logic [CW-1:0] COL_LO = CW'(PAD);
      localparam logic [CW-1:0] COL_HI = CW'(PAD + IMG_W - 1);
      assign w_interior = (w_row >= ROW_LO) && (w_row <= ROW_HI) &&
                          (w_col >= COL_LO) && (w_col <= COL_HI);
    end
  endgenerate

  // Output slot free when empty or being drained this cycle.
  assign w_slot   = !r_out_valid || out_ready;
  assign w_run    = (r_state == PAD_RUN);
  assign w_load   = w_slot && w_run && (!w_interior || in_valid);
  assign in_ready = w_slot && w_run && w_interior && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= PAD_IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else begin
      case (r_state)
        PAD_IDLE: if (en) r_state <= PAD_RUN;
        PAD_RUN:  if (w_load && w_last_pos && !en) r_state <= PAD_IDLE;
        default:  r_state <= PAD_IDLE;
      endcase

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_interior ? in_data : '0;
        r_out_sof   <= (w_row == '0) && (w_col == '0);
        r_out_eol   <= w_last_col;
        r_out_eof   <= w_last_pos;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sof   = r_out_sof;
  assign out_eol   = r_out_eol;
  assign out_eof   = r_out_eof;
  assign busy      = w_run;

`ifdef ZERO_PAD_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // A frame counts once its eof beat is taken downstream; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (r_out_valid && out_ready && r_out_eof) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
